// File: rtl/matmul_operand_loader.sv
// Serial operand loader for the 2x2 signed matrix multiplier: collects eight
// range-checked elements per frame and presents them as packed A/B buses.
module matmul_operand_loader #(
  parameter int ELEM_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [ELEM_W-1:0] s_data,
  input  logic                     s_last,
  output logic [4*ELEM_W-1:0]      a_bus,
  output logic [4*ELEM_W-1:0]      b_bus,
  output logic                     op_valid,
  input  logic                     op_ack,
  output logic                     err_pulse,
  output logic [1:0]               err_code,
  output logic [CNT_W-1:0]         frame_cnt
);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  localparam logic [1:0] CODE_OK    = 2'b00;
  localparam logic [1:0] CODE_RANGE = 2'b01;
  localparam logic [1:0] CODE_SHORT = 2'b10;
  localparam logic [1:0] CODE_LONG  = 2'b11;

  localparam logic [ELEM_W-1:0] MOST_NEG = {1'b1, {(ELEM_W-1){1'b0}}};

  // The most negative code has no positive counterpart, so it is excluded.
  function automatic logic elem_illegal(input logic [ELEM_W-1:0] d);
    return (d == MOST_NEG);
  endfunction

  state_t                r_state;
  state_t                w_state_nxt;
  logic [2:0]            r_idx;
  logic [2:0]            w_idx_nxt;
  logic                  r_bad;
  logic                  w_bad_nxt;
  logic                  w_bad_cur;
  logic [ELEM_W-1:0]     r_shadow [8];
  logic [4*ELEM_W-1:0]   r_a_bus;
  logic [4*ELEM_W-1:0]   r_b_bus;
  logic                  r_op_valid;
  logic                  w_op_valid_nxt;
  logic                  r_err_pulse;
  logic                  w_err_pulse_nxt;
  logic [1:0]            r_err_code;
  logic [1:0]            w_err_code_nxt;
  logic [CNT_W-1:0]      r_frame_cnt;
  logic                  w_cnt_inc;
  logic                  w_load_bus;
  logic                  w_shadow_we;
  logic                  w_ready;
  logic                  w_xfer;

  assign w_ready = rst_n & ena & ((r_state == LOAD) | (r_state == DISCARD));
  assign w_xfer  = s_valid & w_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_idx_nxt       = r_idx;
    w_bad_nxt       = r_bad;
    w_bad_cur       = r_bad;
    w_op_valid_nxt  = r_op_valid;
    w_err_pulse_nxt = 1'b0;
    w_err_code_nxt  = r_err_code;
    w_cnt_inc       = 1'b0;
    w_load_bus      = 1'b0;
    w_shadow_we     = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_xfer) begin
          w_shadow_we = 1'b1;
          w_bad_cur   = r_bad | elem_illegal(s_data);
          if (s_last && (r_idx == 3'd7)) begin
            w_idx_nxt = 3'd0;
            w_bad_nxt = 1'b0;
            if (!w_bad_cur) begin
              w_load_bus     = 1'b1;
              w_op_valid_nxt = 1'b1;
              w_err_code_nxt = CODE_OK;
              w_state_nxt    = HOLD;
            end else begin
              w_err_pulse_nxt = 1'b1;
              w_err_code_nxt  = CODE_RANGE;
            end
          end else if (s_last) begin
            // A short frame is reported as such even if it also held a bad element.
            w_err_pulse_nxt = 1'b1;
            w_err_code_nxt  = CODE_SHORT;
            w_idx_nxt       = 3'd0;
            w_bad_nxt       = 1'b0;
          end else if (r_idx == 3'd7) begin
            w_err_pulse_nxt = 1'b1;
            w_err_code_nxt  = CODE_LONG;
            w_idx_nxt       = 3'd0;
            w_bad_nxt       = 1'b0;
            w_state_nxt     = DISCARD;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_bad_nxt = w_bad_cur;
          end
        end
      end
      DISCARD: begin
        if (w_xfer && s_last) begin
          w_idx_nxt   = 3'd0;
          w_bad_nxt   = 1'b0;
          w_state_nxt = LOAD;
        end
      end
      HOLD: begin
        if (op_ack && ena) begin
          w_op_valid_nxt = 1'b0;
          w_cnt_inc      = 1'b1;
          w_state_nxt    = LOAD;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_idx_nxt   = 3'd0;
        w_bad_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx       <= 3'd0;
      r_bad       <= 1'b0;
      r_op_valid  <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_code  <= CODE_OK;
      r_frame_cnt <= '0;
    end else begin
      r_idx       <= w_idx_nxt;
      r_bad       <= w_bad_nxt;
      r_op_valid  <= w_op_valid_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_code  <= w_err_code_nxt;
      if (w_cnt_inc) r_frame_cnt <= r_frame_cnt + 1'b1;
    end
  end

  // The final element is taken straight from s_data as it is not yet in shadow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) r_shadow[k] <= '0;
      r_a_bus <= '0;
      r_b_bus <= '0;
    end else begin
      if (w_shadow_we) r_shadow[r_idx] <= s_data;
      if (w_load_bus) begin
        r_a_bus <= {r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]};
        r_b_bus <= {s_data, r_shadow[6], r_shadow[5], r_shadow[4]};
      end
    end
  end

  assign s_ready   = w_ready;
  assign a_bus     = r_a_bus;
  assign b_bus     = r_b_bus;
  assign op_valid  = r_op_valid;
  assign err_pulse = r_err_pulse;
  assign err_code  = r_err_code;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_matmul_operand_loader.sv
// Directed bench for matmul_operand_loader: per-cycle vector table plus a
// frame-counter wrap sequence with interleaved rejected frames.
module tb_matmul_operand_loader;

  logic       clk = 1'b0;
  logic       rst_n, ena, s_valid, s_last, op_ack;
  logic [1:0] s_data;
  logic       s_ready, op_valid, err_pulse;
  logic [7:0] a_bus, b_bus, frame_cnt;
  logic [1:0] err_code;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  matmul_operand_loader #(.ELEM_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .a_bus(a_bus), .b_bus(b_bus),
    .op_valid(op_valid), .op_ack(op_ack), .err_pulse(err_pulse),
    .err_code(err_code), .frame_cnt(frame_cnt)
  );

  typedef struct {
    logic       rn, en, v;
    logic [1:0] d;
    logic       l, ack;
    logic       rdy, ov, ep;
    logic [1:0] ec;
    logic [7:0] a, b, cnt;
  } vec_t;

  vec_t vq[$];

  // Frames packed as {b_bus, a_bus}; element idx k sits at bits [2k+1:2k].
  localparam logic [15:0] F1   = 16'hD471;
  localparam logic [15:0] F2   = 16'h350F;
  localparam logic [15:0] BAD  = 16'hD461;
  localparam logic [15:0] LONG = 16'h5555;

  task automatic add(input logic rn, en, v, input logic [1:0] d, input logic l, ack,
                     input logic rdy, ov, ep, input logic [1:0] ec,
                     input logic [7:0] a, b, cnt);
    vec_t t;
    t.rn = rn; t.en = en; t.v = v; t.d = d; t.l = l; t.ack = ack;
    t.rdy = rdy; t.ov = ov; t.ep = ep; t.ec = ec; t.a = a; t.b = b; t.cnt = cnt;
    vq.push_back(t);
  endtask

  task automatic add_elems(input logic [15:0] f, input int first, input int count,
                           input logic [1:0] ec, input logic [7:0] a, b, cnt);
    for (int k = first; k < first + count; k++)
      add(1, 1, 1, f[2*k +: 2], 0, 0, 1, 0, 0, ec, a, b, cnt);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", nm, idx, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] f);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      ena = 1; s_valid = 1; s_data = f[2*k +: 2]; s_last = (k == 7); op_ack = 0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    s_valid = 0; s_last = 0;
  endtask

  initial begin
    int model;
    rst_n = 0; ena = 1; s_valid = 0; s_data = 0; s_last = 0; op_ack = 0;

    add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 8'd0);
    // good frame, HOLD with backpressure, ack, stray ack
    add_elems(F1, 0, 7, 2'b00, 8'h00, 8'h00, 8'd0);
    add(1, 1, 1, 2'b11, 1, 0, 1, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd0);
    add(1, 1, 0, 2'b00, 0, 0, 0, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd0);
    add(1, 1, 1, 2'b10, 1, 0, 0, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd0);
    add(1, 1, 1, 2'b10, 1, 0, 0, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd0);
    add(1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 8'h71, 8'hD4, 8'd1);
    add(1, 1, 0, 2'b00, 0, 1, 1, 0, 0, 2'b00, 8'h71, 8'hD4, 8'd1);
    // range error then good frame
    add_elems(BAD, 0, 7, 2'b00, 8'h71, 8'hD4, 8'd1);
    add(1, 1, 1, 2'b11, 1, 0, 1, 0, 1, 2'b01, 8'h71, 8'hD4, 8'd1);
    add_elems(F2, 0, 7, 2'b01, 8'h71, 8'hD4, 8'd1);
    add(1, 1, 1, 2'b00, 1, 0, 1, 1, 0, 2'b00, 8'h0F, 8'h35, 8'd1);
    add(1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 8'h0F, 8'h35, 8'd2);
    // short frame containing an illegal element, then good frame
    add_elems(BAD, 0, 4, 2'b00, 8'h0F, 8'h35, 8'd2);
    add(1, 1, 1, 2'b00, 1, 0, 1, 0, 1, 2'b10, 8'h0F, 8'h35, 8'd2);
    add_elems(F1, 0, 7, 2'b10, 8'h0F, 8'h35, 8'd2);
    add(1, 1, 1, 2'b11, 1, 0, 1, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd2);
    add(1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 8'h71, 8'hD4, 8'd3);
    // long frame of 10, then good frame
    add_elems(LONG, 0, 7, 2'b00, 8'h71, 8'hD4, 8'd3);
    add(1, 1, 1, 2'b01, 0, 0, 1, 0, 1, 2'b11, 8'h71, 8'hD4, 8'd3);
    add(1, 1, 1, 2'b10, 0, 0, 1, 0, 0, 2'b11, 8'h71, 8'hD4, 8'd3);
    add(1, 1, 1, 2'b01, 1, 0, 1, 0, 0, 2'b11, 8'h71, 8'hD4, 8'd3);
    add_elems(F2, 0, 7, 2'b11, 8'h71, 8'hD4, 8'd3);
    add(1, 1, 1, 2'b00, 1, 0, 1, 1, 0, 2'b00, 8'h0F, 8'h35, 8'd3);
    add(1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 8'h0F, 8'h35, 8'd4);
    // ena low mid-frame and during HOLD
    add_elems(F1, 0, 4, 2'b00, 8'h0F, 8'h35, 8'd4);
    for (int k = 0; k < 4; k++)
      add(1, 0, 1, 2'b10, 1, 0, 0, 0, 0, 2'b00, 8'h0F, 8'h35, 8'd4);
    add_elems(F1, 4, 3, 2'b00, 8'h0F, 8'h35, 8'd4);
    add(1, 1, 1, 2'b11, 1, 0, 1, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd4);
    add(1, 0, 0, 2'b00, 0, 1, 0, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd4);
    add(1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 8'h71, 8'hD4, 8'd5);
    // reset mid-HOLD
    add_elems(F2, 0, 7, 2'b00, 8'h71, 8'hD4, 8'd5);
    add(1, 1, 1, 2'b00, 1, 0, 1, 1, 0, 2'b00, 8'h0F, 8'h35, 8'd5);
    add(0, 1, 1, 2'b01, 0, 1, 0, 0, 0, 2'b00, 8'h00, 8'h00, 8'd0);
    add(1, 1, 0, 2'b00, 0, 0, 1, 0, 0, 2'b00, 8'h00, 8'h00, 8'd0);
    // reset mid-LOAD after an error code is set; the remainder is then short
    add_elems(F1, 0, 2, 2'b00, 8'h00, 8'h00, 8'd0);
    add(1, 1, 1, 2'b11, 1, 0, 1, 0, 1, 2'b10, 8'h00, 8'h00, 8'd0);
    add_elems(F1, 0, 4, 2'b10, 8'h00, 8'h00, 8'd0);
    add(0, 1, 1, 2'b01, 0, 0, 0, 0, 0, 2'b00, 8'h00, 8'h00, 8'd0);
    add_elems(F1, 4, 3, 2'b00, 8'h00, 8'h00, 8'd0);
    add(1, 1, 1, 2'b11, 1, 0, 1, 0, 1, 2'b10, 8'h00, 8'h00, 8'd0);
    add_elems(F1, 0, 7, 2'b10, 8'h00, 8'h00, 8'd0);
    add(1, 1, 1, 2'b11, 1, 0, 1, 1, 0, 2'b00, 8'h71, 8'hD4, 8'd0);
    add(1, 1, 0, 2'b00, 0, 1, 0, 0, 0, 2'b00, 8'h71, 8'hD4, 8'd1);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n = vq[i].rn; ena = vq[i].en; s_valid = vq[i].v;
      s_data = vq[i].d; s_last = vq[i].l; op_ack = vq[i].ack;
      #1;
      chk("s_ready", i, 32'(s_ready), 32'(vq[i].rdy));
      @(posedge clk); #1;
      chk("op_valid", i, 32'(op_valid), 32'(vq[i].ov));
      chk("err_pulse", i, 32'(err_pulse), 32'(vq[i].ep));
      chk("err_code", i, 32'(err_code), 32'(vq[i].ec));
      chk("a_bus", i, 32'(a_bus), 32'(vq[i].a));
      chk("b_bus", i, 32'(b_bus), 32'(vq[i].b));
      chk("frame_cnt", i, 32'(frame_cnt), 32'(vq[i].cnt));
    end

    // wrap: 256 delivered frames with rejected frames interleaved
    @(negedge clk);
    rst_n = 0; ena = 1; s_valid = 0; s_last = 0; op_ack = 0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1;
    model = 0;
    for (int i = 0; i < 256; i++) begin
      if (i % 32 == 5) begin
        send(BAD);
        chk("wrap_rej_pulse", i, 32'(err_pulse), 32'd1);
        chk("wrap_rej_ov", i, 32'(op_valid), 32'd0);
      end
      send(F1);
      chk("wrap_ov", i, 32'(op_valid), 32'd1);
      op_ack = 1;
      @(posedge clk); #1;
      op_ack = 0;
      model = (model + 1) % 256;
      chk("wrap_cnt", i, 32'(frame_cnt), 32'(model));
    end
    chk("wrap_zero", 256, 32'(frame_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
